// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one external memory port shared by instruction
// fetch and MEM-stage data accesses, with a hung-bus watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        branch_taken,
    input  logic        hazard,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic        ext_ready,
    input  logic [31:0] ext_rdata,
    output logic [31:0] instr_out,
    output logic        freeze_if,
    output logic        flush_if,
    output logic        pc_advance,
    output logic        freeze_pipe,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, ERR} state_t;

    state_t        state_q;
    logic          ext_req_q;
    logic          ext_we_q;
    logic [31:0]   ext_addr_q;
    logic [31:0]   ext_wdata_q;
    logic [31:0]   ibuf_q;
    logic          ibuf_valid_q;
    logic          discard_q;
    logic          bus_err_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          data_req;
    logic          in_err;

    assign data_req = mem_rd_en | mem_wr_en;
    assign in_err   = (state_q == ERR);

    // Watchdog count saturates so it can never wrap back below TIMEOUT.
    assign cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign bus_err   = bus_err_q;

    assign instr_out   = ibuf_q;
    assign flush_if    = branch_taken;
    assign freeze_if   = ~ibuf_valid_q | hazard | in_err;
    assign pc_advance  = ibuf_valid_q & ~hazard & ~branch_taken & ~in_err;
    assign mem_done    = (state_q == DATA) & ext_ready;
    assign mem_rdata   = ext_rdata;
    assign freeze_pipe = (data_req & ~mem_done) | in_err;

    // Port sequencer: picks data over fetch, holds a request until ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ext_req_q    <= 1'b0;
            ext_we_q     <= 1'b0;
            ext_addr_q   <= '0;
            ext_wdata_q  <= '0;
            ibuf_q       <= 32'hE000_0000;
            ibuf_valid_q <= 1'b0;
            discard_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (branch_taken || pc_advance) begin
                ibuf_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (data_req) begin
                        state_q     <= DATA;
                        ext_req_q   <= 1'b1;
                        ext_we_q    <= mem_wr_en;
                        ext_addr_q  <= mem_addr;
                        ext_wdata_q <= mem_wdata;
                        cnt_q       <= '0;
                    end else if (!ibuf_valid_q) begin
                        state_q    <= FETCH;
                        ext_req_q  <= 1'b1;
                        ext_we_q   <= 1'b0;
                        ext_addr_q <= if_pc;
                        cnt_q      <= '0;
                    end
                end
                FETCH, DATA: begin
                    if (ext_ready) begin
                        state_q   <= IDLE;
                        ext_req_q <= 1'b0;
                        if (state_q == FETCH) begin
                            discard_q <= 1'b0;
                            if (!discard_q && !branch_taken) begin
                                ibuf_q       <= ext_rdata;
                                ibuf_valid_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        // A redirected fetch stays on the bus; its word is dropped.
                        if (state_q == FETCH && branch_taken) begin
                            discard_q <= 1'b1;
                        end
                        if (cnt_d == CW'(TIMEOUT)) begin
                            state_q   <= ERR;
                            ext_req_q <= 1'b0;
                            bus_err_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single external memory port shared by instruction fetch and the MEM stage. It issues fetches from the current PC into a one-entry instruction buffer, and drives `freeze`/`flush` and `Instruction_in` of the IF stage register. It also serves MEM-stage loads and stores with priority over fetch, stalling the pipeline until each data access completes. A watchdog converts a hung memory into a sticky error.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles a request may wait for `ext_ready` before error.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_pc`  in  32  address of next instruction to fetch.
- `branch_taken`  in  1  EX-stage redirect; flush request.
- `hazard`  in  1  hazard unit stall request for IF.
- `mem_rd_en` / `mem_wr_en`  in  1 each  MEM-stage access request; held until `mem_done`.
- `mem_addr`, `mem_wdata`  in  32 each  MEM-stage address and store data.
- `ext_req`  out  1  memory request; held until accepted.
- `ext_we`  out  1  1 = write.
- `ext_addr`, `ext_wdata`  out  32 each  request address and data.
- `ext_ready`  in  1  completion strobe; valid only while `ext_req`=1.
- `ext_rdata`  in  32  read data, valid with `ext_ready`.
- `instr_out`  out  32  to IF register `Instruction_in` (buffer contents).
- `freeze_if`  out  1  to IF register `freeze`.
- `flush_if`  out  1  to IF register `flush`.
- `pc_advance`  out  1  PC may load next value this cycle.
- `freeze_pipe`  out  1  stall ID/EX/MEM while a data access is pending.
- `mem_rdata`  out  32  load data, valid with `mem_done`.
- `mem_done`  out  1  one-cycle completion pulse for data access.
- `bus_err`  out  1  sticky watchdog error.

## Operation
- States: `IDLE`, `FETCH`, `DATA`, `ERR`.
- `IDLE`:
  - `mem_rd_en|mem_wr_en` → `DATA`. Latch `mem_addr`, `mem_wdata`, and `ext_we`=`mem_wr_en`.
  - Otherwise, if `ibuf_valid`=0 → `FETCH`. Latch `if_pc`, `ext_we`=0.
  - Data always wins over fetch.
- `FETCH`/`DATA`: `ext_req`=1 (registered) and `ext_addr`/`ext_we`/`ext_wdata` stable until the edge at which `ext_ready`=1 is sampled. At that edge → `IDLE` and `ext_req`←0.
- Fetch completion: `ibuf`←`ext_rdata`, `ibuf_valid`←1, unless `discard`=1. In that case data is dropped and `discard`←0.
- Data completion: `mem_done`=1 and `mem_rdata`=`ext_rdata`, combinational in the ready cycle.
- Instruction buffer and IF control:
  - `instr_out`=`ibuf`.
  - `freeze_if` = `~ibuf_valid | hazard | (state==ERR)`.
  - `pc_advance` = `ibuf_valid & ~hazard & ~branch_taken & (state!=ERR)`; on `pc_advance`, `ibuf_valid`←0.
  - `flush_if` = `branch_taken`.
- Branch handling:
  - `branch_taken` clears `ibuf_valid`.
  - If `state==FETCH` at that time, `discard`←1. A request in flight is never withdrawn.
- `freeze_pipe` = `(mem_rd_en|mem_wr_en) & ~mem_done`, or 1 in `ERR`.
- Watchdog:
  - Counter is reset on entry to `FETCH`/`DATA` and increments each cycle `ext_req`=1 and `ext_ready`=0.
  - Reaching `TIMEOUT` → `ERR`, with `ext_req`←0 and `bus_err`←1.
  - `ERR` is left only by reset.
- Counter width is `$clog2(TIMEOUT+1)` and saturates.

## Timing
- Reset values:
  - State `IDLE`; `ext_req`, `ext_we`, `ext_addr`, `ext_wdata` = 0.
  - `ibuf`=32'hE000_0000; `ibuf_valid`=0; `discard`=0; `bus_err`=0; counter 0.
  - Hence `freeze_if`=1 out of reset.
- Fetch, zero-wait memory:
  - Cycle t0: `IDLE`, decide.
  - t1: `ext_req`=1, `ext_ready`=1.
  - t2: `ibuf_valid`=1, `pc_advance`=1; IF register captures at end of t2.
  - Earliest next fetch request is t4 (PC updates at t2 edge, then `IDLE` decide at t3).
- Each memory wait cycle adds one cycle to both fetch and data latency.
- Data access: `mem_done` is in the first cycle `ext_ready`=1, at the earliest t1 after the request is seen in `IDLE` at t0.
- Simultaneous `branch_taken` and fetch completion: the data is discarded and `ibuf_valid` stays 0.
- Simultaneous `branch_taken` and `pc_advance`: `pc_advance` is suppressed and flush wins.
- Data request arriving while `FETCH` is in flight: it waits for fetch completion, then is served from `IDLE`.
- Asynchronous reset mid-transaction drops `ext_req` immediately. Memory must tolerate an abandoned request.

## Test plan
- Reset: release `rst` with `ext_ready` tied 1 and `if_pc`=0x100 → `ext_addr`=0x100 and `ext_req`=1 at t1. Then `instr_out`=`ext_rdata`=0xE3A01005 with `freeze_if`=0 at t2.
- Wait states: `ext_ready` delayed 3 cycles → `ext_req` held 4 cycles with `ext_addr` stable; single `pc_advance` pulse afterwards.
- Load priority: `mem_rd_en`=1 and `mem_addr`=0x2000 while `ibuf_valid`=0 in `IDLE` → data request issued first, `ext_we`=0, `mem_done` pulse, `freeze_pipe` low the following cycle. Fetch of `if_pc` follows.
- Store during fetch: `mem_wr_en` asserted while `FETCH` waits 2 cycles → fetch completes first. Then write with `ext_we`=1 and `ext_wdata`=0xDEADBEEF.
- Branch mid-fetch: `branch_taken` pulse in cycle 2 of a 4-cycle fetch → `flush_if`=1 that cycle; returned word dropped, `ibuf_valid`=0; next fetch uses new `if_pc`.
- Hazard and watchdog:
  - `hazard`=1 with `ibuf_valid`=1 → `freeze_if`=1, `pc_advance`=0, buffer held.
  - `ext_ready` stuck 0 with `TIMEOUT`=8 → `bus_err`=1 after 8 cycles; `ext_req`=0, both freezes held until reset.
